instr_encoder: RTL and testbench

- Streaming RV32I instruction encoder: the inverse of the main/ALU decode path.
- Accepts symbolic instruction requests (class, registers, immediate) and emits 32-bit machine words with sequential instruction-memory addresses.
- Used by the boot/program loader and the verification harness to fill instruction memory for the single-cycle core.
- Covers exactly the classes the core decodes: lw, sw, R-type, beq, I-type ALU, jal.

---
 rtl/instr_encoder.sv | 150 +++++++++++++++
 tb/tb_instr_encoder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Streaming RV32I encoder: turns symbolic requests (lw/sw/R/beq/I-ALU/jal) into
// machine words tagged with sequential instruction-memory byte addresses.
module instr_encoder #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              restart,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [2:0]        in_funct3,
  input  logic              in_sub,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic              err_seen,
  output logic [15:0]       out_count
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_BRNCH = 7'b1100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_instr_q, out_instr_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic              out_err_q, out_err_d;
  logic              err_seen_q, err_seen_d;
  logic [15:0]       out_count_q, out_count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic signed [31:0] imm_s;
  logic [31:0]        enc_word;
  logic               enc_err;
  logic               is_shift;
  logic               accept;
  logic               xfer;
  logic [ADDR_W-1:0]  base_addr;

  assign imm_s    = $signed(in_imm);
  assign is_shift = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);

  always_comb begin
    enc_word = '0;
    enc_err  = 1'b0;
    case (in_kind)
      3'd0: begin
        enc_err  = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
        enc_word = {in_imm[11:0], in_rs1, 3'b010, in_rd, OP_LOAD};
      end
      3'd1: begin
        enc_err  = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
        enc_word = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], OP_STORE};
      end
      3'd2: begin
        enc_err  = in_sub && (in_funct3 != 3'b000) && (in_funct3 != 3'b101);
        enc_word = {1'b0, in_sub, 5'b00000, in_rs2, in_rs1, in_funct3, in_rd, OP_REG};
      end
      3'd3: begin
        enc_err  = (imm_s < -32'sd4096) || (imm_s > 32'sd4094) || in_imm[0];
        enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000,
                    in_imm[4:1], in_imm[11], OP_BRNCH};
      end
      3'd4: begin
        // Shifts carry funct7 in the upper immediate bits, so the range is the shamt.
        if (is_shift) begin
          enc_err  = (imm_s < 32'sd0) || (imm_s > 32'sd31);
          enc_word = {1'b0, in_sub, 5'b00000, in_imm[4:0], in_rs1, in_funct3, in_rd, OP_IMM};
        end else begin
          enc_err  = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
          enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_IMM};
        end
        if (in_sub && (in_funct3 != 3'b101)) enc_err = 1'b1;
      end
      3'd5: begin
        enc_err  = (imm_s < -32'sd1048576) || (imm_s > 32'sd1048574) || in_imm[0];
        enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OP_JAL};
      end
      default: enc_err = 1'b1;
    endcase
    if (enc_err) enc_word = '0;
  end

  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign xfer      = out_valid_q && out_ready;
  assign base_addr = restart ? BASE_ADDR : addr_q;

  always_comb begin
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_addr_d  = out_addr_q;
    out_err_d   = out_err_q;
    addr_d      = base_addr;
    err_seen_d  = restart ? 1'b0 : err_seen_q;
    out_count_d = out_count_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_instr_d = enc_word;
      out_addr_d  = base_addr;
      out_err_d   = enc_err;
      addr_d      = base_addr + ADDR_W'(4);
      if (enc_err) err_seen_d = 1'b1;
    end else if (xfer) begin
      out_valid_d = 1'b0;
    end
    // restart wins over a concurrent transfer, so the count restarts from zero.
    if (restart)                              out_count_d = '0;
    else if (xfer && (out_count_q != 16'hFFFF)) out_count_d = out_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_addr_q  <= BASE_ADDR;
      out_err_q   <= 1'b0;
      err_seen_q  <= 1'b0;
      out_count_q <= '0;
      addr_q      <= BASE_ADDR;
    end else begin
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_addr_q  <= out_addr_d;
      out_err_q   <= out_err_d;
      err_seen_q  <= err_seen_d;
      out_count_q <= out_count_d;
      addr_q      <= addr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_addr  = out_addr_q;
  assign out_err   = out_err_q;
  assign err_seen  = err_seen_q;
  assign out_count = out_count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed scenarios with known words, then random
// traffic scored against a field-level reference model.
module tb_instr_encoder;

  localparam logic [31:0] BASE = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        restart = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_kind = '0;
  logic [2:0]  in_funct3 = '0;
  logic        in_sub = 1'b0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [31:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        out_err;
  logic        err_seen;
  logic [15:0] out_count;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(32), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset_n(reset_n), .restart(restart),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_funct3(in_funct3), .in_sub(in_sub), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_imm(in_imm), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err),
    .err_seen(err_seen), .out_count(out_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  // model of the output register and bookkeeping
  bit          m_valid, m_err, m_seen;
  logic [31:0] m_instr, m_addr, m_ctr;
  int          m_count;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void ref_encode(input int kind, input logic [2:0] f3, input bit sub,
                                     input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [4:0] rs2, input int imm,
                                     output logic [31:0] w, output bit e);
    logic [31:0] iv;
    iv = imm;
    w  = '0;
    e  = 1'b0;
    case (kind)
      0: begin
        e = (imm < -2048) || (imm > 2047);
        w[31:20] = iv[11:0]; w[19:15] = rs1; w[14:12] = 3'd2; w[11:7] = rd; w[6:0] = 7'h03;
      end
      1: begin
        e = (imm < -2048) || (imm > 2047);
        w[31:25] = iv[11:5]; w[24:20] = rs2; w[19:15] = rs1; w[14:12] = 3'd2;
        w[11:7] = iv[4:0]; w[6:0] = 7'h23;
      end
      2: begin
        e = sub && !(f3 == 3'd0 || f3 == 3'd5);
        w[30] = sub; w[24:20] = rs2; w[19:15] = rs1; w[14:12] = f3; w[11:7] = rd; w[6:0] = 7'h33;
      end
      3: begin
        e = (imm < -4096) || (imm > 4094) || (imm % 2 != 0);
        w[31] = iv[12]; w[30:25] = iv[10:5]; w[24:20] = rs2; w[19:15] = rs1;
        w[11:8] = iv[4:1]; w[7] = iv[11]; w[6:0] = 7'h63;
      end
      4: begin
        if (f3 == 3'd1 || f3 == 3'd5) begin
          e = (imm < 0) || (imm > 31);
          w[30] = sub; w[24:20] = iv[4:0];
        end else begin
          e = (imm < -2048) || (imm > 2047);
          w[31:20] = iv[11:0];
        end
        if (sub && f3 != 3'd5) e = 1'b1;
        w[19:15] = rs1; w[14:12] = f3; w[11:7] = rd; w[6:0] = 7'h13;
      end
      5: begin
        e = (imm < -1048576) || (imm > 1048574) || (imm % 2 != 0);
        w[31] = iv[20]; w[30:21] = iv[10:1]; w[20] = iv[11]; w[19:12] = iv[19:12];
        w[11:7] = rd; w[6:0] = 7'h6F;
      end
      default: e = 1'b1;
    endcase
    if (e) w = '0;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_err = 0; m_seen = 0; m_count = 0;
    m_instr = '0; m_ctr = BASE; m_addr = BASE;
  endtask

  task automatic drive(input int kind, input int f3, input bit sub, input int rd,
                       input int rs1, input int rs2, input int imm);
    in_valid  = 1'b1;
    in_kind   = kind[2:0];
    in_funct3 = f3[2:0];
    in_sub    = sub;
    in_rd     = rd[4:0];
    in_rs1    = rs1[4:0];
    in_rs2    = rs2[4:0];
    in_imm    = imm;
  endtask

  // One clock cycle: called just after a falling edge with inputs applied.
  task automatic step();
    bit          rdy, acc, xfer, e;
    logic [31:0] w, base;
    #1;
    rdy  = !m_valid || out_ready;
    check("in_ready", in_ready, rdy);
    acc  = in_valid && rdy;
    xfer = m_valid && out_ready;
    ref_encode(in_kind, in_funct3, in_sub, in_rd, in_rs1, in_rs2, int'(in_imm), w, e);
    base = restart ? BASE : m_ctr;
    if (restart) begin m_seen = 0; m_count = 0; end
    else if (xfer && m_count < 65535) m_count++;
    m_ctr = base;
    if (acc) begin
      m_valid = 1; m_instr = w; m_err = e; m_addr = base; m_ctr = base + 4;
      if (e) m_seen = 1;
    end else if (xfer) begin
      m_valid = 0;
    end
    @(posedge clk);
    #1;
    check("out_valid", out_valid, m_valid);
    check("err_seen", err_seen, m_seen);
    check("out_count", out_count, m_count);
    if (m_valid) begin
      check("out_instr", out_instr, m_instr);
      check("out_addr", out_addr, m_addr);
      check("out_err", out_err, m_err);
    end
    @(negedge clk);
  endtask

  function automatic int rand_imm();
    int bnd[18] = '{-2049, -2048, 2047, 2048, -4097, -4096, 4094, 4095, 4096,
                    -1048577, -1048576, 1048574, 1048575, 1048576, -1, 0, 31, 32};
    case ($urandom_range(5))
      0: return int'($urandom_range(80)) - 40;
      1: return bnd[$urandom_range(17)];
      2: return int'($urandom_range(10000)) - 5000;
      3: return int'($urandom);
      4: return int'($urandom_range(40));
      default: return int'($urandom_range(4194304)) - 2097152;
    endcase
  endfunction

  logic [31:0] addr_before;

  initial begin
    model_reset();
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 1'b0);
    check("rst_instr", out_instr, 32'h0);
    check("rst_err", out_err, 1'b0);
    check("rst_seen", err_seen, 1'b0);
    check("rst_count", out_count, 16'h0);
    check("rst_addr", out_addr, BASE);
    @(negedge clk);
    reset_n = 1'b1;

    // gapless stream
    drive(0, 0, 0, 6, 9, 0, -4);          step(); check("lw_word", out_instr, 32'hFFC4A303);
    check("lw_addr", out_addr, BASE);
    drive(1, 0, 0, 0, 9, 6, 8);           step(); check("sw_word", out_instr, 32'h0064A423);
    check("sw_addr", out_addr, BASE + 4);
    drive(2, 6, 0, 4, 5, 6, 0);           step(); check("or_word", out_instr, 32'h0062E233);
    drive(3, 0, 0, 0, 4, 4, 16);          step(); check("beq_word", out_instr, 32'h00420863);
    drive(5, 0, 0, 1, 0, 0, 8);           step(); check("jal_word", out_instr, 32'h008000EF);
    check("jal_addr", out_addr, BASE + 16);
    in_valid = 1'b0;                      step(); check("stream_count", out_count, 16'd5);

    // backpressure with a held request
    out_ready = 1'b0;
    drive(4, 0, 0, 2, 0, 0, 1);           step();
    drive(4, 0, 0, 3, 0, 0, 2);
    repeat (3) step();
    check("bp_stall_ready", in_ready, 1'b0);
    out_ready = 1'b1;                     step();
    drive(4, 0, 0, 4, 0, 0, 3);           step();
    in_valid = 1'b0;                      step();

    // error word then a clean one
    addr_before = m_ctr;
    drive(3, 0, 0, 0, 1, 2, 3);           step();
    check("err_word", out_instr, 32'h0);
    check("err_flag", out_err, 1'b1);
    check("err_sticky", err_seen, 1'b1);
    drive(4, 0, 0, 1, 0, 0, 5);           step();
    check("addi_word", out_instr, 32'h00500093);
    check("addi_err", out_err, 1'b0);
    check("addi_sticky", err_seen, 1'b1);
    check("addi_addr", out_addr, addr_before + 4);

    // restart with a concurrent accept
    restart = 1'b1;
    drive(2, 0, 1, 7, 8, 9, 0);           step();
    restart = 1'b0;
    check("rs_addr", out_addr, BASE);
    check("rs_count", out_count, 16'd0);
    check("rs_seen", err_seen, 1'b0);
    in_valid = 1'b0;                      step();
    check("rs_count1", out_count, 16'd1);

    // async reset while stalled
    out_ready = 1'b0;
    drive(0, 0, 0, 1, 2, 0, 12);          step();
    #1 reset_n = 1'b0;
    #1 check("async_rst_valid", out_valid, 1'b0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    out_ready = 1'b1;
    drive(0, 0, 0, 1, 2, 0, 12);          step();
    check("post_rst_addr", out_addr, BASE);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(9) < 7);
      out_ready = ($urandom_range(9) < 7);
      restart   = ($urandom_range(15) == 0);
      in_kind   = 3'($urandom_range(7));
      in_funct3 = 3'($urandom_range(7));
      in_sub    = ($urandom_range(3) == 0);
      in_rd     = 5'($urandom);
      in_rs1    = 5'($urandom);
      in_rs2    = 5'($urandom);
      in_imm    = rand_imm();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
